// File: rtl/systolic_output_collector.sv
// Systolic array bottom-edge collector: de-skews columns into rows, buffers and drains them.
// Build with OUTPUT_RELU_EN defined to clamp negative column values to zero on FIFO write.
module systolic_output_collector #(
  parameter int NUM_COLS               = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH             = 8,
  parameter int ROW_COUNT_WIDTH        = 16
) (
  input  logic                                       CLK,
  input  logic                                       SYNC_RST,
  input  logic                                       Start,
  input  logic [ROW_COUNT_WIDTH-1:0]                 RowCount,
  input  logic [NUM_COLS*ACCUMULATOR_DATA_WIDTH-1:0] PsumIn,
  input  logic                                       PsumValid,
  output logic [NUM_COLS*ACCUMULATOR_DATA_WIDTH-1:0] OutData,
  output logic                                       OutValid,
  input  logic                                       OutReady,
  output logic                                       Stall,
  output logic                                       Busy,
  output logic                                       Done,
  output logic                                       Overflow
);

  localparam int W   = ACCUMULATOR_DATA_WIDTH;
  localparam int RW  = NUM_COLS * W;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int VW  = NUM_COLS - 1;
  localparam int RCW = ROW_COUNT_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]     state;
  logic [RCW-1:0] target;
  logic [RCW-1:0] rows;
  logic [RCW-1:0] rows_inc;
  logic           done_q;
  logic           ovf_q;

  logic [RW-1:0]  aligned;
  logic [RW-1:0]  wdata;
  logic [VW-1:0]  vpipe;
  logic           row_valid;

  logic [RW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  free;
  logic           full;
  logic           push;
  logic           pop;
  logic           push_ok;

  // Column c arrives c cycles late, so it is held NUM_COLS-1-c cycles.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    localparam int D = NUM_COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*W +: W] = PsumIn[c*W +: W];
    end else begin : g_dly
      logic [W-1:0] sr [D];
      always_ff @(posedge CLK) begin
        if (!SYNC_RST) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= PsumIn[c*W +: W];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[c*W +: W] = sr[D-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!SYNC_RST) vpipe <= '0;
    else           vpipe <= (vpipe << 1) | VW'(PsumValid);
  end

  assign row_valid = vpipe[VW-1];

  always_comb begin
    wdata = aligned;
`ifdef OUTPUT_RELU_EN
    for (int i = 0; i < NUM_COLS; i++) begin
      if (aligned[i*W+W-1]) wdata[i*W +: W] = '0;
    end
`endif
  end

  assign OutValid = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = OutValid && OutReady;
  assign push     = (state == S_COLLECT) && row_valid;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok  = push && (!full || pop);
  assign free     = CW'(FIFO_DEPTH) - count;
  assign OutData  = OutValid ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (!SYNC_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  assign rows_inc = rows + RCW'(1);

  always_ff @(posedge CLK) begin
    if (!SYNC_RST) begin
      state  <= S_IDLE;
      target <= '0;
      rows   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (Start) begin
            target <= RowCount;
            rows   <= '0;
            ovf_q  <= 1'b0;
            state  <= (RowCount == '0) ? S_DRAIN : S_COLLECT;
          end
        end
        (state == S_COLLECT): begin
          if (row_valid) begin
            rows <= rows_inc;
            if (full && !pop) ovf_q <= 1'b1;
            if (rows_inc == target) state <= S_DRAIN;
          end
        end
        (state == S_DRAIN): begin
          if (!OutValid) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Stall    = (state == S_COLLECT) && (free <= CW'(NUM_COLS));
  assign Busy     = (state != S_IDLE);
  assign Done     = done_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Bench for systolic_output_collector: directed jobs plus random jobs against a
// queue-based row model; OUTPUT_RELU_EN selects the clamped expectation.
module tb_systolic_output_collector;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int DEP = 8;
  localparam int RCW = 16;
  localparam int RW  = N * W;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_DRAIN   = 2;

  logic           CLK = 1'b0;
  logic           SYNC_RST;
  logic           Start;
  logic [RCW-1:0] RowCount;
  logic [RW-1:0]  PsumIn;
  logic           PsumValid;
  logic [RW-1:0]  OutData;
  logic           OutValid;
  logic           OutReady;
  logic           Stall;
  logic           Busy;
  logic           Done;
  logic           Overflow;

  systolic_output_collector #(
    .NUM_COLS(N),
    .ACCUMULATOR_DATA_WIDTH(W),
    .FIFO_DEPTH(DEP),
    .ROW_COUNT_WIDTH(RCW)
  ) dut (
    .CLK(CLK),
    .SYNC_RST(SYNC_RST),
    .Start(Start),
    .RowCount(RowCount),
    .PsumIn(PsumIn),
    .PsumValid(PsumValid),
    .OutData(OutData),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Stall(Stall),
    .Busy(Busy),
    .Done(Done),
    .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  logic          issue;
  logic [RW-1:0] issue_data;
  logic [RW-1:0] issued [int];
  logic [RW-1:0] fifo_q [$];
  int            m_mode;
  int            m_target;
  int            m_rows;
  bit            m_ovf;
  bit            m_done;

  int done_seen;
  int done_cyc;
  int first_valid_cyc;
  int delivered;

  task automatic chk(string tag, logic [RW-1:0] obs, logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cur);
    end
  endtask

  function automatic logic [RW-1:0] relu(logic [RW-1:0] r);
    logic [RW-1:0] o;
    o = r;
`ifdef OUTPUT_RELU_EN
    for (int c = 0; c < N; c++) begin
      if (r[c*W+W-1]) o[c*W +: W] = '0;
    end
`endif
    return o;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int c = 0; c < N; c++) r[c*W +: W] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    issued.delete();
    m_mode   = M_IDLE;
    m_target = 0;
    m_rows   = 0;
    m_ovf    = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic check_outputs();
    logic [RW-1:0] exp_data;
    exp_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    chk("out_valid", OutValid, fifo_q.size() > 0);
    chk("out_data", OutData, exp_data);
    chk("stall", Stall, (m_mode == M_COLLECT) && ((DEP - fifo_q.size()) <= N));
    chk("busy", Busy, m_mode != M_IDLE);
    chk("done", Done, m_done);
    chk("overflow", Overflow, m_ovf);
  endtask

  // One clock of the reference: a row issued at cycle t is a full row at t+N-1.
  task automatic model_step();
    bit            pop;
    bit            aligned;
    int            old_mode;
    int            size_before;
    logic [RW-1:0] row;
    if (!SYNC_RST) begin
      model_reset();
      return;
    end
    old_mode    = m_mode;
    size_before = fifo_q.size();
    pop         = (size_before > 0) && OutReady;
    aligned     = issued.exists(cur - (N - 1));
    row         = aligned ? relu(issued[cur-(N-1)]) : '0;
    m_done      = 1'b0;
    if (pop) void'(fifo_q.pop_front());
    if (old_mode == M_IDLE && Start) begin
      m_target = int'(RowCount);
      m_rows   = 0;
      m_ovf    = 1'b0;
      m_mode   = (RowCount == 0) ? M_DRAIN : M_COLLECT;
    end else if (old_mode == M_COLLECT && aligned) begin
      m_rows++;
      if (fifo_q.size() < DEP) fifo_q.push_back(row);
      else m_ovf = 1'b1;
      if (m_rows == m_target) m_mode = M_DRAIN;
    end else if (old_mode == M_DRAIN && size_before == 0) begin
      m_mode = M_IDLE;
      m_done = 1'b1;
    end
  endtask

  task automatic tick();
    logic [RW-1:0] pin;
    logic [RW-1:0] src;
    PsumValid = 1'b0;
    if (issue && SYNC_RST) begin
      issued[cur] = issue_data;
      PsumValid   = 1'b1;
    end
    for (int c = 0; c < N; c++) begin
      if (issued.exists(cur - c)) begin
        src = issued[cur-c];
        pin[c*W +: W] = src[c*W +: W];
      end else begin
        pin[c*W +: W] = $urandom;
      end
    end
    PsumIn = pin;
    check_outputs();
    if (Done) begin
      done_seen++;
      done_cyc = cur;
    end
    if (OutValid && first_valid_cyc < 0) first_valid_cyc = cur;
    if (OutValid && OutReady) delivered++;
    model_step();
    @(posedge CLK);
    #1;
    cur++;
  endtask

  task automatic start_job(int rc);
    done_seen = 0;
    delivered = 0;
    first_valid_cyc = -1;
    RowCount = RCW'(rc);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic run_until_done(string tag, int budget);
    int n;
    n = 0;
    issue = 1'b0;
    while (done_seen == 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done_seen > 0, 1'b1);
  endtask

  initial begin
    int first_issue;
    int n_issued;
    int n;
    int rc;
    int start_cyc;
    bit stall_seen;
    logic [RW-1:0] r;
    logic [W-1:0]  exp_c2;

    SYNC_RST = 1'b0;
    Start = 1'b0;
    RowCount = '0;
    PsumIn = '0;
    PsumValid = 1'b0;
    OutReady = 1'b0;
    issue = 1'b0;
    issue_data = '0;
    done_seen = 0;
    done_cyc = 0;
    first_valid_cyc = -1;
    delivered = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    SYNC_RST = 1'b1;
    tick();

    // Job 1: three skewed rows, col c = 10*row + c, free-running sink.
    OutReady = 1'b1;
    start_job(3);
    first_issue = cur;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < N; c++) r[c*W +: W] = W'(10 * i + c);
      issue = 1'b1;
      issue_data = r;
      tick();
    end
    issue = 1'b0;
    run_until_done("t1_done", 20);
    chk("t1_latency", first_valid_cyc - first_issue, N);
    chk("t1_delivered", delivered, 3);
    repeat (3) tick();
    chk("t1_done_once", done_seen, 1);

    // Job 2: blocked sink, upstream honours Stall.
    OutReady = 1'b0;
    start_job(8);
    n_issued = 0;
    stall_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (Stall) stall_seen = 1'b1;
      issue = (n_issued < 8) && !Stall;
      issue_data = rand_row();
      tick();
      if (issue) n_issued++;
    end
    chk("t2_stall_seen", stall_seen, 1'b1);
    chk("t2_no_overflow_blocked", Overflow, 1'b0);
    OutReady = 1'b1;
    n = 0;
    while (done_seen == 0 && n < 60) begin
      issue = (n_issued < 8) && !Stall;
      issue_data = rand_row();
      tick();
      if (issue) n_issued++;
      n++;
    end
    issue = 1'b0;
    chk("t2_done", done_seen > 0, 1'b1);
    chk("t2_delivered", delivered, 8);
    chk("t2_no_overflow", Overflow, 1'b0);

    // Job 3: ten back-to-back rows ignoring Stall into a blocked sink.
    OutReady = 1'b0;
    start_job(10);
    for (int i = 0; i < 10; i++) begin
      issue = 1'b1;
      issue_data = rand_row();
      tick();
    end
    issue = 1'b0;
    repeat (6) tick();
    chk("t3_overflow", Overflow, 1'b1);
    chk("t3_busy_full", Busy, 1'b1);
    chk("t3_no_early_done", done_seen, 0);
    OutReady = 1'b1;
    run_until_done("t3_done", 30);
    chk("t3_delivered", delivered, 8);

    // Job 4: negative value in column 2.
    start_job(1);
    for (int c = 0; c < N; c++) r[c*W +: W] = W'(c + 1);
    r[2*W +: W] = -W'(5);
    issue = 1'b1;
    issue_data = r;
    tick();
    issue = 1'b0;
    n = 0;
    while (!OutValid && n < 10) begin
      tick();
      n++;
    end
    chk("t4_valid", OutValid, 1'b1);
`ifdef OUTPUT_RELU_EN
    exp_c2 = '0;
`else
    exp_c2 = -W'(5);
`endif
    chk("t4_col2", OutData[2*W +: W], exp_c2);
    chk("t4_col1", OutData[1*W +: W], W'(2));
    chk("t4_col3", OutData[3*W +: W], W'(4));
    run_until_done("t4_done", 20);

    // Job 5: reset with three rows buffered, then rows while idle.
    OutReady = 1'b0;
    start_job(8);
    for (int i = 0; i < 3; i++) begin
      issue = 1'b1;
      issue_data = rand_row();
      tick();
    end
    issue = 1'b0;
    repeat (4) tick();
    chk("t5_buffered_busy", Busy, 1'b1);
    SYNC_RST = 1'b0;
    tick();
    SYNC_RST = 1'b1;
    chk("t5_rst_valid", OutValid, 1'b0);
    chk("t5_rst_busy", Busy, 1'b0);
    chk("t5_rst_stall", Stall, 1'b0);
    OutReady = 1'b1;
    delivered = 0;
    for (int i = 0; i < 3; i++) begin
      issue = 1'b1;
      issue_data = rand_row();
      tick();
    end
    issue = 1'b0;
    repeat (8) tick();
    chk("t5_idle_no_output", delivered, 0);

    // Job 6: empty job, plus a Start while busy that must be ignored.
    start_cyc = cur;
    start_job(0);
    RowCount = RCW'(5);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    run_until_done("t6_done", 10);
    chk("t6_done_latency", done_cyc - start_cyc, 2);
    repeat (4) tick();
    chk("t6_done_once", done_seen, 1);
    chk("t6_busy_after", Busy, 1'b0);
    chk("t6_no_output", delivered, 0);

    // Random jobs: random issue gaps, random sink readiness, extra rows.
    for (int j = 0; j < 6; j++) begin
      rc = $urandom_range(1, 12);
      start_job(rc);
      n_issued = 0;
      n = 0;
      while (done_seen == 0 && n < 300) begin
        OutReady = ($urandom_range(0, 3) != 0);
        issue = (n_issued < rc + 2) && ($urandom_range(0, 3) != 0);
        issue_data = rand_row();
        tick();
        if (issue) n_issued++;
        n++;
      end
      issue = 1'b0;
      chk("rand_done", done_seen > 0, 1'b1);
      OutReady = 1'b1;
      repeat (6) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_output_collector.md
Name: systolic_output_collector

Overview:
Sits at the bottom edge of the weight-stationary systolic array and consumes the PsumOut values leaving each Processing_Element column. Columns emit skewed in time: column c is one cycle later than column c-1. The block de-skews the columns into aligned output rows, buffers them in a FIFO, and drains them over a valid/ready stream. It also raises back-pressure (Stall) to the array controller and reports completion of a programmed row count.

Parameters:
NUM_COLS, 4, number of array columns; also the skew depth
ACCUMULATOR_DATA_WIDTH, 32, width of one signed partial sum
FIFO_DEPTH, 8, aligned rows buffered; power of two, minimum NUM_COLS+2
ROW_COUNT_WIDTH, 16, width of RowCount

Ports:
CLK  input  1  clock, rising edge
SYNC_RST  input  1  synchronous reset, active-low (0 = reset, sampled on CLK rising edge)
Start  input  1  one-cycle pulse that begins a collection job; honoured only in IDLE
RowCount  input  ROW_COUNT_WIDTH  rows expected in the job; sampled on Start; 0 is legal
PsumIn  input  NUM_COLS*ACCUMULATOR_DATA_WIDTH  bottom-row PsumOut of all columns; column 0 in the LSBs, signed
PsumValid  input  1  column 0 data valid this cycle; column c data valid c cycles later
OutData  output  NUM_COLS*ACCUMULATOR_DATA_WIDTH  aligned row at the FIFO head
OutValid  output  1  FIFO not empty
OutReady  input  1  downstream accepts OutData when OutValid && OutReady
Stall  output  1  array controller must deassert array EN
Busy  output  1  state != IDLE
Done  output  1  one-cycle pulse at job completion
Overflow  output  1  sticky: an aligned row was dropped because the FIFO was full

Behaviour:
Reset (SYNC_RST == 0 at a rising edge), any state, including mid-job:
- FIFO emptied; deskew registers and valid pipeline cleared; row counter = 0; state = IDLE.
- OutValid, Stall, Busy, Done and Overflow all 0. OutData = 0.

Deskew:
- Column c data passes through NUM_COLS-1-c register stages.
- A delayed copy of PsumValid passes through NUM_COLS-1 stages and marks the aligned row.
- When PsumValid is high in cycle t, the full aligned row is written to the FIFO at the edge ending cycle t+NUM_COLS-1.
- If the FIFO was empty, OutValid rises in cycle t+NUM_COLS (first-word latency NUM_COLS).
- Back-to-back PsumValid gives one row per cycle.

State machine:
- IDLE: PsumValid and pipeline contents are ignored (no write, no Overflow). On Start, latch RowCount, clear the row counter, clear Overflow, and go to COLLECT. If RowCount == 0, go straight to DRAIN instead.
- COLLECT: each aligned-valid row increments the row counter and attempts a FIFO write. When the counter reaches RowCount, go to DRAIN. Aligned rows beyond RowCount are discarded.
- DRAIN: no writes. When the FIFO is empty, pulse Done for one cycle and return to IDLE.
- Start outside IDLE is ignored.

FIFO:
- Pop on OutValid && OutReady.
- Simultaneous push and pop while full: the pop happens first, so the push succeeds.
- Push while full with no pop: row dropped, Overflow set (sticky until next Start or reset), row still counted.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.

Stall:
- Combinational: Stall = (free entries <= NUM_COLS) and state == COLLECT.
- This covers the rows already in flight in the deskew pipeline, so an upstream that obeys Stall never sees Overflow.

Arithmetic:
- Data is passed through unmodified; no width change.

Optional Feature:
Macro OUTPUT_RELU_EN.
- Defined: each column value is clamped to 0 if negative (sign bit set) at FIFO write time, per column independently.
- Undefined: values are stored bit-exact.
- Timing and handshake are identical in both builds.

Test Plan:
1. Reset, then Start with RowCount=3; drive PsumValid for 3 consecutive cycles with columns skewed (col c = 10*row+c, each column one cycle later); OutReady=1 -> rows {0,1,2,3}, {10,11,12,13}, {20,21,22,23} out in order; first OutValid exactly 4 cycles after the first PsumValid; Done pulses once; Busy falls with Done.
2. OutReady=0, RowCount=8, continuous PsumValid while honouring Stall -> Stall asserts when free entries <= 4; after releasing OutReady all 8 rows are delivered intact; Overflow stays 0.
3. Ignore Stall with FIFO_DEPTH=8, RowCount=10, OutReady=0 -> Overflow=1; FIFO holds the first 8 rows; Done occurs only after all 8 are drained.
4. Negative psum -5 in column 2 -> OutData column 2 = -5 without OUTPUT_RELU_EN, 0 with it; other columns unchanged.
5. Pull SYNC_RST low mid-COLLECT with 3 rows buffered -> next cycle OutValid=0, Busy=0, Stall=0; subsequent PsumValid in IDLE produces no output.
6. Start with RowCount=0 -> Done pulses within 2 cycles and no OutValid; a second Start issued while Busy is ignored.
